des_key_schedule: RTL and testbench

//  Sequential DES round-key generator. Sits directly downstream of the key-path trojan stage.

---
 rtl/des_key_schedule.sv | 104 ++++++++++
 tb/tb_des_key_schedule.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: emits the 16 PC-2 subkeys one per clock,
// forward (K1..K16) or reversed (K16..K1) from a captured post-PC-1 key.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [55:0] key,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] PC2 [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
    6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
    6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
    6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
    6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  state_t      state, state_nx;
  logic [27:0] c_q, d_q, c_nx, d_nx;
  logic [4:0]  r_q, r_nx, slot_nx;
  logic        dec_q, dec_nx;
  logic        single;

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // CD bit n (1-based from the MSB) lives at {C,D}[56-n]
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-int'(PC2[i])];
    return o;
  endfunction

  // For slots 2..16 the encrypt set s(n) and the decrypt set s(18-n)
  // both reduce to single-bit shifts at slots 2, 9 and 16.
  assign slot_nx = r_q + 5'd1;
  assign single  = (slot_nx == 5'd2) || (slot_nx == 5'd9) || (slot_nx == 5'd16);

  always_comb begin
    state_nx = state;
    c_nx     = c_q;
    d_nx     = d_q;
    r_nx     = r_q;
    dec_nx   = dec_q;
    case (state)
      IDLE: if (start) begin
        state_nx = RUN;
        dec_nx   = decrypt;
        r_nx     = 5'd1;
        c_nx     = decrypt ? key[55:28] : rotl(key[55:28], 1'b0);
        d_nx     = decrypt ? key[27:0]  : rotl(key[27:0],  1'b0);
      end
      RUN: begin
        if (r_q == 5'd16) begin
          state_nx = IDLE;
        end else begin
          r_nx = slot_nx;
          c_nx = dec_q ? rotr(c_q, !single) : rotl(c_q, !single);
          d_nx = dec_q ? rotr(d_q, !single) : rotl(d_q, !single);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c_q   <= '0;
      d_q   <= '0;
      r_q   <= '0;
      dec_q <= 1'b0;
    end else begin
      state <= state_nx;
      c_q   <= c_nx;
      d_q   <= d_nx;
      r_q   <= r_nx;
      dec_q <= dec_nx;
    end
  end

  // round is 4 bits wide, so slot 16 reads as 4'h0; valid/done disambiguate it
  assign busy         = (state == RUN);
  assign subkey_valid = busy;
  assign subkey       = busy ? pc2({c_q, d_q}) : '0;
  assign round        = busy ? r_q[3:0] : 4'd0;
  assign done         = busy && (r_q == 5'd16);

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed and randomized checks of des_key_schedule against hand values and a
// from-scratch key-schedule model (cumulative left shifts from C0/D0).
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [55:0] key = '0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  des_key_schedule dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key(key),
    .subkey(subkey), .subkey_valid(subkey_valid), .round(round),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [55:0] K_T1 = 56'hF0CCAAF556678F;
  localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int PC2T [48] = '{
    14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

  int tests = 0;
  int fails = 0;
  logic [47:0] obs [16];
  logic [3:0]  obs_rnd [16];
  logic        obs_vld [16];
  logic        obs_busy [16];
  logic        obs_done [16];
  int          n_done;
  logic [47:0] exp_k [16];
  logic [47:0] t1_k [16];

  task automatic model(input logic [55:0] k, input logic dec);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] kk [16];
    c = k[55:28];
    d = k[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < SH[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int b = 0; b < 48; b++) kk[i][47-b] = cd[56-PC2T[b]];
    end
    for (int j = 0; j < 16; j++) exp_k[j] = dec ? kk[15-j] : kk[j];
  endtask

  // called at a negedge; returns at the negedge where slot 1 is visible
  task automatic launch(input logic [55:0] k, input logic dec);
    start = 1'b1;
    key = k;
    decrypt = dec;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic capture();
    n_done = 0;
    for (int i = 0; i < 16; i++) begin
      obs[i] = subkey; obs_rnd[i] = round; obs_vld[i] = subkey_valid;
      obs_busy[i] = busy; obs_done[i] = done;
      if (done) n_done++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({subkey, subkey_valid, round, busy, done} !== 55'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h/%b/%h/%b/%b want all 0", subkey, subkey_valid, round, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({subkey_valid, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_reset: valid/busy/done got %b%b%b want 000", subkey_valid, busy, done);
    end
  endtask

  task automatic test_encrypt();
    int bad;
    launch(K_T1, 1'b0);
    capture();
    for (int i = 0; i < 16; i++) t1_k[i] = obs[i];
    tests++;
    if (obs[0] !== 48'h1B02EFFC7072) begin fails++; $display("FAIL enc_k1: got %h want 1b02effc7072", obs[0]); end
    tests++;
    if (obs[1] !== 48'h79AED9DBC9E5) begin fails++; $display("FAIL enc_k2: got %h want 79aed9dbc9e5", obs[1]); end
    tests++;
    if (obs[15] !== 48'hCB3D8B0E17F5) begin fails++; $display("FAIL enc_k16: got %h want cb3d8b0e17f5", obs[15]); end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (obs_vld[i] !== 1'b1 || obs_busy[i] !== 1'b1 || obs_rnd[i] !== 4'(i+1)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL enc_valid_rounds: got %0d bad slots want 0", bad); end
    tests++;
    if (n_done != 1 || obs_done[15] !== 1'b1) begin
      fails++; $display("FAIL enc_done: got count %0d last %b want 1 1", n_done, obs_done[15]);
    end
    tests++;
    if ({subkey, subkey_valid, round, busy, done} !== 55'd0) begin
      fails++; $display("FAIL enc_after_end: got %h/%b/%h/%b want all 0", subkey, subkey_valid, round, busy);
    end
    model(K_T1, 1'b0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (obs[i] !== exp_k[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL enc_model: got %0d mismatching subkeys want 0", bad); end
  endtask

  task automatic test_decrypt();
    int bad;
    launch(K_T1, 1'b1);
    capture();
    tests++;
    if (obs[0] !== 48'hCB3D8B0E17F5) begin fails++; $display("FAIL dec_slot1: got %h want cb3d8b0e17f5", obs[0]); end
    tests++;
    if (obs[14] !== 48'h79AED9DBC9E5) begin fails++; $display("FAIL dec_slot15: got %h want 79aed9dbc9e5", obs[14]); end
    tests++;
    if (obs[15] !== 48'h1B02EFFC7072) begin fails++; $display("FAIL dec_slot16: got %h want 1b02effc7072", obs[15]); end
    bad = 0;
    for (int i = 0; i < 16; i++) if (obs[i] !== t1_k[15-i] || obs_rnd[i] !== 4'(i+1)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL dec_reverse: got %0d bad slots want 0", bad); end
    tests++;
    if (n_done != 1 || obs_done[15] !== 1'b1) begin fails++; $display("FAIL dec_done: got %0d want 1", n_done); end
  endtask

  task automatic test_trojan();
    int bad, diff;
    launch(K_T1 ^ 56'd1, 1'b0);
    capture();
    model(K_T1 ^ 56'd1, 1'b0);
    bad = 0; diff = 0;
    for (int i = 0; i < 16; i++) begin
      if (obs[i] !== exp_k[i]) bad++;
      if (obs[i] !== t1_k[i]) diff++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL trojan_model: got %0d mismatching subkeys want 0", bad); end
    tests++;
    if (diff == 0) begin fails++; $display("FAIL trojan_differs: got 0 differing subkeys want >0"); end
  endtask

  task automatic test_hold_start();
    int bad;
    start = 1'b1; key = K_T1; decrypt = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      obs[i] = subkey; obs_rnd[i] = round;
      if (i == 2) begin key = ~K_T1; decrypt = 1'b1; end
      @(negedge clk);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (obs[i] !== t1_k[i] || obs_rnd[i] !== 4'(i+1)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL hold_start_seq: got %0d bad slots want 0", bad); end
    // start still high here, in the IDLE cycle after done: a new schedule is accepted
    tests++;
    if (subkey_valid !== 1'b0) begin fails++; $display("FAIL hold_start_gap: valid got %b want 0", subkey_valid); end
    launch(K_T1, 1'b0);
    capture();
    bad = 0;
    for (int i = 0; i < 16; i++) if (obs[i] !== t1_k[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL back_to_back_seq: got %0d bad slots want 0", bad); end
    @(negedge clk);
    tests++;
    if (subkey_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL no_spurious_start: valid/busy got %b%b want 00", subkey_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    launch(K_T1, 1'b0);
    repeat (6) @(negedge clk);
    tests++;
    if (round !== 4'd7) begin fails++; $display("FAIL mid_round7: got %0d want 7", round); end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({subkey, subkey_valid, round, busy, done} !== 55'd0) begin
      fails++; $display("FAIL mid_reset_outputs: got %h/%b/%h/%b/%b want all 0", subkey, subkey_valid, round, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (subkey_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_reset_idle: valid/busy got %b%b want 00", subkey_valid, busy);
    end
    launch(K_T1, 1'b0);
    capture();
    bad = 0;
    for (int i = 0; i < 16; i++) if (obs[i] !== t1_k[i] || obs_rnd[i] !== 4'(i+1)) bad++;
    tests++;
    if (bad != 0 || n_done != 1) begin
      fails++; $display("FAIL mid_reset_restart: got %0d bad slots, %0d done want 0, 1", bad, n_done);
    end
  endtask

  task automatic test_random();
    int bad, gapbad, starts, dones;
    logic [55:0] k;
    logic d;
    bad = 0; gapbad = 0; starts = 0; dones = 0;
    for (int it = 0; it < 1000; it++) begin
      k = {24'($urandom()), 32'($urandom())};
      d = 1'($urandom_range(0, 1));
      launch(k, d);
      starts++;
      capture();
      dones += n_done;
      model(k, d);
      for (int i = 0; i < 16; i++)
        if (obs[i] !== exp_k[i] || obs_vld[i] !== 1'b1 || obs_rnd[i] !== 4'(i+1)) bad++;
      if (subkey_valid !== 1'b0) gapbad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL random_model: got %0d bad slots want 0", bad); end
    tests++;
    if (dones != starts) begin fails++; $display("FAIL random_done_count: got %0d want %0d", dones, starts); end
    tests++;
    if (gapbad != 0) begin fails++; $display("FAIL random_gap: got %0d valid gaps want 0", gapbad); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_encrypt();
    test_decrypt();
    test_trojan();
    test_hold_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
